ps2_host_tx: RTL

- Host-to-device PS/2 transmitter; the send side of the keyboard link that currently only receives scan codes.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the open-drain inhibit/request-to-send sequence, then checks the device ACK.
- Sits on the 50 MHz processor clock domain next to the PS/2 receiver; is fed from a memory-mapped I/O store.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_host_tx_if.sv | 21 ++
 rtl/ps2_line_sync.sv | 35 +++
 rtl/ps2_host_tx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state set, error codes and
// frame geometry, plus the parity helper used when loading a frame.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    // start + 8 data + parity + stop
    localparam int unsigned PS2_FRAME_BITS = 11;

    // Odd parity bit: ones(d) + parity is always odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between the MMIO store logic and the PS/2 host
// transmitter, with completion/error status coming back.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx_busy, tx_done, tx_err, err_code
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx_busy, tx_done, tx_err, err_code
    );
endinterface

// File: rtl/ps2_line_sync.sv
// PS/2 pad conditioning for one clock/data line pair: SYNC_STAGES-deep
// synchronizers (SYNC_STAGES >= 2) and a falling-edge flag on the clock line.
// Idle-high lines, so the flops reset to 1 and no edge is seen after reset.
module ps2_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);
    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] data_sr;
    logic                   clk_prev;

    // Shift both pads through their synchronizer chains; remember last clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sr   <= '1;
            data_sr  <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sr   <= {clk_sr[SYNC_STAGES-2:0], clk_in};
            data_sr  <= {data_sr[SYNC_STAGES-2:0], data_in};
            clk_prev <= clk_sr[SYNC_STAGES-1];
        end
    end

    assign clk_sync  = clk_sr[SYNC_STAGES-1];
    assign data_sync = data_sr[SYNC_STAGES-1];
    assign clk_fall  = clk_prev & ~clk_sr[SYNC_STAGES-1];
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10 bits clocked
// out by the device, ACK check, then wait for an idle bus.
// Optional build macro PS2_TX_RETRY_EN: one automatic retry from INHIBIT
// with the same byte after a timeout or missing ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic         clock,
    input  logic         reset,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int unsigned IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // INHIBIT lasts one cycle less than INHIBIT_CYCLES: the RTS cycle keeps
    // the clock low too, so the pad sees exactly INHIBIT_CYCLES low cycles.
    localparam logic [IW-1:0] INH_LAST     = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_DATA_FE = 4'(PS2_FRAME_BITS - 2);

    ps2_state_e    state_q;
    ps2_state_e    state_d;
    logic          clk_sync;
    logic          data_sync;
    logic          clk_fall;
    logic [7:0]    data_q;
    logic [9:0]    shift_q;
    logic          cur_bit_q;
    logic [3:0]    bit_cnt_q;
    logic [IW-1:0] inh_cnt_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          idle_prev_q;
    logic          ack_ok_q;
    logic          done_q;
    logic          err_q;
    logic [1:0]    err_code_q;
    logic          accept;
    logic          timeout;
    logic          fail;
    logic          retry_now;
    logic          line_idle;
`ifdef PS2_TX_RETRY_EN
    logic          retry_used_q;
`endif

    ps2_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .clk_in   (ps2_clk_in),
        .data_in  (ps2_data_in),
        .clk_sync (clk_sync),
        .data_sync(data_sync),
        .clk_fall (clk_fall)
    );

    assign accept    = (state_q == IDLE) && tx.tx_valid;
    assign timeout   = ((state_q == SEND) || (state_q == ACK)) && (tmo_cnt_q == TMO_LAST);
    assign fail      = timeout || ((state_q == ACK) && clk_fall && data_sync);
    assign line_idle = clk_sync && data_sync;
`ifdef PS2_TX_RETRY_EN
    assign retry_now = fail && !retry_used_q;
`else
    assign retry_now = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a timeout wins over a clock edge in the same cycle.
    always_comb begin
        state_d = state_q;
        if (fail) begin
            state_d = retry_now ? INHIBIT : WAIT_IDLE;
        end else begin
            case (state_q)
                IDLE:      if (accept) state_d = INHIBIT;
                INHIBIT:   if (inh_cnt_q == INH_LAST) state_d = RTS;
                RTS:       state_d = SEND;
                SEND:      if (clk_fall && (bit_cnt_q == LAST_DATA_FE)) state_d = ACK;
                ACK:       if (clk_fall) state_d = WAIT_IDLE;
                WAIT_IDLE: if (idle_prev_q && line_idle) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Frame datapath: byte latch, bit shifter, counters and status pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q      <= '0;
            shift_q     <= '1;
            cur_bit_q   <= 1'b1;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            idle_prev_q <= 1'b0;
            ack_ok_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
            retry_used_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept) begin
                data_q   <= tx.tx_data;
                ack_ok_q <= 1'b0;
            end
            inh_cnt_q <= (state_q == INHIBIT) ? inh_cnt_q + 1'b1 : '0;
            if (state_q == RTS) begin
                // Reloaded per attempt so a retry resends the latched byte.
                shift_q   <= {1'b1, odd_parity(data_q), data_q};
                cur_bit_q <= 1'b0;
                bit_cnt_q <= '0;
                tmo_cnt_q <= '0;
            end else if ((state_q == SEND) || (state_q == ACK)) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if ((state_q == SEND) && clk_fall && !timeout) begin
                cur_bit_q <= shift_q[0];
                shift_q   <= {1'b1, shift_q[9:1]};
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if ((state_q == ACK) && clk_fall && !timeout && !data_sync) begin
                ack_ok_q <= 1'b1;
            end
            idle_prev_q <= (state_q == WAIT_IDLE) && line_idle;
            if (fail && !retry_now) begin
                err_q      <= 1'b1;
                err_code_q <= timeout ? ERR_TIMEOUT : ERR_NOACK;
            end
            if ((state_q == WAIT_IDLE) && (state_d == IDLE) && ack_ok_q) begin
                done_q <= 1'b1;
            end
`ifdef PS2_TX_RETRY_EN
            if (accept) begin
                retry_used_q <= 1'b0;
            end else if (retry_now) begin
                retry_used_q <= 1'b1;
            end
`endif
        end
    end

    // Outputs: handshake/status and open-drain enables decoded from state.
    always_comb begin
        tx.tx_ready = (state_q == IDLE);
        tx.tx_busy  = (state_q != IDLE);
        tx.tx_done  = done_q;
        tx.tx_err   = err_q;
        tx.err_code = err_code_q;
        ps2_clk_oe  = (state_q == INHIBIT) || (state_q == RTS);
        ps2_data_oe = (state_q == RTS) || ((state_q == SEND) && !cur_bit_q);
    end
endmodule
